uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer placed directly downstream of the UART receiver.

---
 rtl/uart_rx_fifo.sv | 86 ++++++++
 tb/tb_uart_rx_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: captures rcv strobes and presents the oldest byte first-word-fall-through.
// Optional build macro UART_RX_FIFO_OVERWRITE_EN: a byte arriving at a full FIFO overwrites the oldest entry instead of being dropped.
module uart_rx_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rcv,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          valid,
    input  logic          ready,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          pop;
    logic          push;
    logic          ovf_evt;
    logic          wr_en;
    logic          rd_adv;
    logic [AW:0]   level_nxt;

    // Handshake decode; a full FIFO can still accept a byte when it is popping in the same cycle.
    always_comb begin
        pop       = valid & ready;
        push      = rcv & (~full | pop);
        ovf_evt   = rcv & full & ~pop;
        wr_en     = push;
        rd_adv    = pop;
        level_nxt = level;
`ifdef UART_RX_FIFO_OVERWRITE_EN
        // Overwrite the oldest slot: wr_ptr equals rd_ptr when full, so both advance together.
        if (ovf_evt) begin
            wr_en  = 1'b1;
            rd_adv = 1'b1;
        end
`endif
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            valid    <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_nxt;
            valid    <= (level_nxt != '0);
            full     <= (level_nxt == LW'(DEPTH));
            // A new loss event takes priority over a coincident clear.
            overflow <= (overflow & ~ovf_clr) | ovf_evt;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          rcv;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          valid;
    logic          ready;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;

    logic [7:0]    q [$];
    logic          ovf_m;
    int            vectors;
    int            miscompares;

    always #5 clk = ~clk;

    uart_rx_fifo #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rcv      (rcv),
        .din      (din),
        .dout     (dout),
        .valid    (valid),
        .ready    (ready),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},    32'(valid),    32'(q.size() != 0));
        chk({tag, ".level"},    32'(level),    32'(q.size()));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
        if (q.size() != 0) begin
            chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
        end
    endtask

    // One clock with the given inputs; the model applies the FIFO rules to the pre-edge contents.
    task automatic step(input string tag, input logic r, input logic [7:0] d,
                        input logic rd, input logic c);
        int  sz;
        bit  do_pop;
        bit  ev;
        rst = 1'b0; rcv = r; din = d; ready = rd; ovf_clr = c;
        @(posedge clk);
        sz     = q.size();
        do_pop = (sz != 0) && rd;
        ev     = 1'b0;
        if (do_pop) void'(q.pop_front());
        if (r) begin
            if (sz < DEPTH || do_pop) begin
                q.push_back(d);
            end else begin
                ev = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
                void'(q.pop_front());
                q.push_back(d);
`endif
            end
        end
        ovf_m = (ovf_m && !c) || ev;
        #1;
        rcv = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        rcv = 1'($urandom); din = 8'($urandom); ready = 1'($urandom); ovf_clr = 1'($urandom);
        @(posedge clk);
        q.delete();
        ovf_m = 1'b0;
        #1;
        rst = 1'b0; rcv = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic fill_seq(input string tag);
        for (int i = 0; i < DEPTH; i++) step(tag, 1'b1, 8'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        ovf_m = 1'b0;
        rst = 1'b1; rcv = 1'b0; din = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
        @(posedge clk);
        do_reset("reset");
        chk("reset.level0", 32'(level), 32'd0);

        // Single byte in and out
        step("t1.push", 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1.dout", 32'(dout), 32'hA5);
        chk("t1.level", 32'(level), 32'd1);
        step("t1.empty_ready", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1.valid0", 32'(valid), 32'd0);
        step("t1.underflow", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full, drain in order across the pointer wrap
        fill_seq("t2.fill");
        chk("t2.full", 32'(full), 32'd1);
        chk("t2.level16", 32'(level), 32'd16);
        drain("t2.drain");

        // Full plus incoming byte without pop
        fill_seq("t3.fill");
        step("t3.ovf", 1'b1, 8'h55, 1'b0, 1'b0);
        chk("t3.overflow", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_OVERWRITE_EN
        chk("t3.dout_next", 32'(dout), 32'h01);
`else
        chk("t3.dout_kept", 32'(dout), 32'h00);
`endif
        drain("t3.drain");

        // Full plus incoming byte with simultaneous pop
        do_reset("t4.reset");
        fill_seq("t4.fill");
        step("t4.push_pop", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4.level16", 32'(level), 32'd16);
        chk("t4.ovf0", 32'(overflow), 32'd0);
        drain("t4.drain");

        // Overflow clear, and set winning over a coincident clear
        fill_seq("t5.fill");
        step("t5.ovf", 1'b1, 8'h99, 1'b0, 1'b0);
        step("t5.clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5.cleared", 32'(overflow), 32'd0);
        step("t5.set_wins", 1'b1, 8'hAA, 1'b0, 1'b1);
        chk("t5.set", 32'(overflow), 32'd1);
        drain("t5.drain");

        // Mid-operation reset discards contents
        for (int i = 0; i < 5; i++) step("t6.push", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        chk("t6.level5", 32'(level), 32'd5);
        do_reset("t6.reset");
        step("t6.fresh", 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("t6.dout", 32'(dout), 32'h3C);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd.reset");
            end else begin
                step("rnd", 1'($urandom_range(0, 2) != 0), 8'($urandom),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
